// File: rtl/wave_trace_pkg.sv
// Shared defaults and helpers for the multi-channel waveform trace renderer.
// Widths, row scaling constants, row-offset width and the per-channel bus slice.
package wave_trace_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 12;
    localparam int PIX_W_DEF  = 11;
    localparam int NUM_CH_DEF = 2;
    localparam int SHIFT_DEF  = 3;
    localparam int Y_BASE_DEF = 48;
    localparam int RD_LAT_DEF = 1;

    function automatic int row_w(input int data_w, input int shift);
        return data_w - shift;
    endfunction

endpackage

`ifndef WT_CH_SLICE
`define WT_CH_SLICE(bus, c, w) bus[(c)*(w) +: (w)]
`endif

// File: rtl/wave_trace_render_if.sv
// Sample RAM read port shared by all trace channels.
// Master issues address/enable, slave returns all channels' samples RD_LAT clocks later.
interface wave_trace_render_if
    import wave_trace_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int NUM_CH = NUM_CH_DEF
) ();
    logic                     ram_rd_en;
    logic [ADDR_W-1:0]        ram_rd_addr;
    logic [NUM_CH*DATA_W-1:0] ram_rd_data;

    modport master (output ram_rd_en, output ram_rd_addr, input  ram_rd_data);
    modport slave  (input  ram_rd_en, input  ram_rd_addr, output ram_rd_data);
endinterface

// File: rtl/wave_trace_cmp.sv
// Per-channel trace hit: scales a sample to a row and compares with the pixel row.
// One registered stage, one pixel per clock, no backpressure.
module wave_trace_cmp
    import wave_trace_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int PIX_W  = PIX_W_DEF,
    parameter int SHIFT  = SHIFT_DEF,
    parameter int Y_BASE = Y_BASE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sample,
    input  logic [PIX_W-1:0]  ypos,
    input  logic              de,
    input  logic              first,
    input  logic              line_mode,
    input  logic              x_valid,
    input  logic              en,
    output logic              flag
);
    localparam int RW = row_w(DATA_W, SHIFT);
    localparam int CW = (PIX_W > RW) ? PIX_W : RW;

    logic [RW-1:0]  cur;
    logic [RW-1:0]  prev;
    logic [RW-1:0]  ref_v;
    logic [CW-1:0]  cur_e;
    logic [CW-1:0]  ref_e;
    logic [CW-1:0]  lo;
    logic [CW-1:0]  hi;
    logic [CW-1:0]  row_u;
    logic [PIX_W:0] row_s;
    logic           hit;

    always_comb begin
        cur   = RW'(sample >> SHIFT);
        // The first column of a line has no predecessor, so it degenerates to a dot.
        ref_v = first ? cur : prev;
        cur_e = CW'(cur);
        ref_e = CW'(ref_v);
        lo    = (ref_e < cur_e) ? ref_e : cur_e;
        hi    = (ref_e < cur_e) ? cur_e : ref_e;
        row_s = {1'b0, ypos} - (PIX_W+1)'(Y_BASE);
        row_u = CW'(row_s[PIX_W-1:0]);
        hit   = 1'b0;
        if (!row_s[PIX_W]) begin
            hit = line_mode ? ((row_u >= lo) && (row_u <= hi)) : (row_u == cur_e);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= '0;
            flag <= 1'b0;
        end else begin
            if (de) begin
                prev <= cur;
            end
            flag <= hit && x_valid && en;
        end
    end

endmodule

// File: rtl/wave_trace_render.sv
// Multi-channel trace renderer: address stage, RAM-latency delay line, per-channel compare.
// Latency 2+RD_LAT clocks, one pixel per clock, never stalls (no backpressure).
module wave_trace_render
    import wave_trace_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int PIX_W  = PIX_W_DEF,
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int SHIFT  = SHIFT_DEF,
    parameter int Y_BASE = Y_BASE_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PIX_W-1:0]     pixel_xpos,
    input  logic [PIX_W-1:0]     pixel_ypos,
    input  logic                 pixel_de,
    input  logic                 mode_line,
    input  logic [NUM_CH-1:0]    ch_en,
    wave_trace_render_if.master  ram,
    output logic [NUM_CH-1:0]    pixel_flag,
    output logic                 pixel_de_o
);
    typedef struct packed {
        logic [PIX_W-1:0] ypos;
        logic             x_valid;
        logic             de;
        logic             line_mode;
    } stage_t;

    stage_t a_q;
    stage_t dl_q [RD_LAT];
    stage_t b;
    logic   de_rise_in;
    logic   first;

    // a_q.de is last cycle's pixel_de, so this marks the start of a line.
    assign de_rise_in = pixel_de && !a_q.de;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram.ram_rd_en   <= 1'b0;
            ram.ram_rd_addr <= '0;
            a_q             <= '0;
        end else begin
            ram.ram_rd_en   <= pixel_de;
            ram.ram_rd_addr <= pixel_xpos[ADDR_W-1:0];
            a_q.ypos        <= pixel_ypos;
            a_q.x_valid     <= pixel_de && ((pixel_xpos >> ADDR_W) == '0);
            a_q.de          <= pixel_de;
            a_q.line_mode   <= de_rise_in ? mode_line : a_q.line_mode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                dl_q[i] <= '0;
            end
        end else begin
            dl_q[0] <= a_q;
            for (int i = 1; i < RD_LAT; i++) begin
                dl_q[i] <= dl_q[i-1];
            end
        end
    end

    assign b = dl_q[RD_LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_de_o <= 1'b0;
        end else begin
            pixel_de_o <= b.de;
        end
    end

    // pixel_de_o holds the previous cycle's delayed de, giving the rising edge for free.
    assign first = b.de && !pixel_de_o;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        wave_trace_cmp #(
            .DATA_W (DATA_W),
            .PIX_W  (PIX_W),
            .SHIFT  (SHIFT),
            .Y_BASE (Y_BASE)
        ) u_cmp (
            .clk       (clk),
            .rst_n     (rst_n),
            .sample    (`WT_CH_SLICE(ram.ram_rd_data, c, DATA_W)),
            .ypos      (b.ypos),
            .de        (b.de),
            .first     (first),
            .line_mode (b.line_mode),
            .x_valid   (b.x_valid),
            .en        (ch_en[c]),
            .flag      (pixel_flag[c])
        );
    end

endmodule

// File: tb/tb_wave_trace_render.sv
// Bench for wave_trace_render: directed lines against a per-pixel reference model,
// plus literal pins on hand-computed pixels.
module tb_wave_trace_render;

    logic        clk;
    logic        rst_n;
    logic [10:0] pixel_xpos;
    logic [10:0] pixel_ypos;
    logic        pixel_de;
    logic        mode_line;
    logic [1:0]  ch_en;
    logic [1:0]  pixel_flag;
    logic        pixel_de_o;

    wave_trace_render_if rif ();

    wave_trace_render dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pixel_xpos (pixel_xpos),
        .pixel_ypos (pixel_ypos),
        .pixel_de   (pixel_de),
        .mode_line  (mode_line),
        .ch_en      (ch_en),
        .ram        (rif.master),
        .pixel_flag (pixel_flag),
        .pixel_de_o (pixel_de_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [11:0] ram0 [1024];
    logic [11:0] ram1 [1024];

    always @(posedge clk) begin
        rif.ram_rd_data <= {ram1[rif.ram_rd_addr], ram0[rif.ram_rd_addr]};
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit       de;
        bit [1:0] hit;
        int       x;
        int       y;
    } ent_t;

    ent_t     pq[$];
    ent_t     e;
    ent_t     zero_e;
    bit       line_on;
    bit       lmode;
    int       prev_off [2];
    bit       started;
    logic [1:0] exp_flag;
    logic     exp_de;
    logic     exp_en;
    logic [9:0] exp_addr;
    int       cur_x, cur_y;
    int       mx, my, moff, mrow, mref, mlo, mhi;
    bit       mfirst;
    logic [1:0] obs [int];

    always @(posedge clk or negedge rst_n) begin
        started = 1'b1;
        if (!rst_n) begin
            zero_e = '{de: 1'b0, hit: 2'b00, x: 0, y: 0};
            pq.delete();
            repeat (3) pq.push_back(zero_e);
            line_on = 1'b0;
            lmode = 1'b0;
            prev_off[0] = 0;
            prev_off[1] = 0;
            exp_flag = 2'b00;
            exp_de = 1'b0;
            exp_en = 1'b0;
            exp_addr = '0;
        end else begin
            mx = int'(pixel_xpos);
            my = int'(pixel_ypos);
            mfirst = pixel_de && !line_on;
            if (mfirst) lmode = mode_line;
            line_on = pixel_de;
            e.de = pixel_de;
            e.x = mx;
            e.y = my;
            e.hit = 2'b00;
            mrow = my - 48;
            for (int c = 0; c < 2; c++) begin
                moff = (c == 0) ? int'(ram0[mx % 1024]) / 8 : int'(ram1[mx % 1024]) / 8;
                mref = mfirst ? moff : prev_off[c];
                if (pixel_de) prev_off[c] = moff;
                mlo = (mref < moff) ? mref : moff;
                mhi = (mref < moff) ? moff : mref;
                if (pixel_de && mx < 1024 && mrow >= 0)
                    e.hit[c] = lmode ? (mrow >= mlo && mrow <= mhi) : (mrow == moff);
            end
            exp_en = pixel_de;
            exp_addr = 10'(mx % 1024);
            pq.push_back(e);
            while (pq.size() > 3) void'(pq.pop_front());
            exp_flag = pq[0].hit & ch_en;
            exp_de = pq[0].de;
            cur_x = pq[0].x;
            cur_y = pq[0].y;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("pixel_flag", 32'(pixel_flag), 32'(exp_flag));
            chk("pixel_de_o", 32'(pixel_de_o), 32'(exp_de));
            chk("ram_rd_en", 32'(rif.ram_rd_en), 32'(exp_en));
            if (exp_en) chk("ram_rd_addr", 32'(rif.ram_rd_addr), 32'(exp_addr));
            if (exp_de) obs[cur_y * 4096 + cur_x] = pixel_flag;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            pixel_de = 1'b0;
        end
    endtask

    task automatic line(input int y, input int x0, input int n, input bit md,
                        input int en_col, input logic [1:0] en_val);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pixel_xpos = 11'(x0 + i);
            pixel_ypos = 11'(y);
            pixel_de   = 1'b1;
            if (i == 0) mode_line = md;
            if (i == n / 2) mode_line = ~md;
            if (x0 + i == en_col) ch_en = en_val;
        end
        idle(2);
    endtask

    task automatic lit(input int x, input int y, input int c, input bit ev);
        int key;
        key = y * 4096 + x;
        if (!obs.exists(key)) begin
            n_checks++;
            n_err++;
            $display("FAIL lit(%0d,%0d) ch%0d: no output observed, expected %0d", x, y, c, ev);
        end else begin
            chk($sformatf("lit(%0d,%0d) ch%0d", x, y, c), 32'(obs[key][c]), 32'(ev));
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0;
        pixel_xpos = '0;
        pixel_ypos = '0;
        pixel_de = 1'b0;
        mode_line = 1'b0;
        ch_en = 2'b01;
        for (int i = 0; i < 1024; i++) begin
            ram0[i] = 12'd400;
            ram1[i] = 12'((i * 8) % 4096);
        end

        // Reset state, with pixel_de toggling underneath
        repeat (2) @(negedge clk);
        pixel_de = 1'b1;
        pixel_xpos = 11'd5;
        pixel_ypos = 11'd98;
        @(negedge clk);
        #1;
        chk("reset pixel_flag", 32'(pixel_flag), 32'd0);
        chk("reset pixel_de_o", 32'(pixel_de_o), 32'd0);
        chk("reset ram_rd_en", 32'(rif.ram_rd_en), 32'd0);
        chk("reset ram_rd_addr", 32'(rif.ram_rd_addr), 32'd0);
        pixel_de = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Latency pin: single dot pixel on row 98, flag appears 3 clocks later
        @(negedge clk);
        pixel_xpos = 11'd7;
        pixel_ypos = 11'd98;
        pixel_de = 1'b1;
        mode_line = 1'b0;
        @(negedge clk);
        pixel_de = 1'b0;
        #1 chk("lat+1 flag", 32'(pixel_flag), 32'd0);
        @(negedge clk);
        #1 chk("lat+2 de_o", 32'(pixel_de_o), 32'd0);
        @(negedge clk);
        #1 chk("lat+3 flag", 32'(pixel_flag), 32'b01);
        chk("lat+3 de_o", 32'(pixel_de_o), 32'd1);
        idle(3);

        // Dot mode, constant sample 400 -> row 98; ch1 disabled
        for (int y = 56; y <= 60; y++) line(y, 0, 16, 1'b0, -1, 2'b01);
        for (int y = 96; y <= 100; y++) line(y, 0, 16, 1'b0, -1, 2'b01);
        idle(4);
        lit(5, 98, 0, 1'b1);
        lit(15, 98, 0, 1'b1);
        lit(5, 97, 0, 1'b0);
        lit(5, 99, 0, 1'b0);
        lit(10, 58, 1, 1'b0);

        // Enable ch1 mid-line: col 10's stage-B edge coincides with the col-12 input
        line(58, 0, 16, 1'b0, 12, 2'b11);
        idle(4);
        lit(10, 58, 1, 1'b1);

        // Line mode step: cols 0..9 = 80 (row 58), cols 10..15 = 240 (row 78)
        for (int i = 0; i < 16; i++) ram0[i] = (i < 10) ? 12'd80 : 12'd240;
        for (int y = 50; y <= 85; y++) line(y, 0, 16, 1'b1, -1, 2'b11);
        idle(4);
        lit(10, 58, 0, 1'b1);
        lit(10, 68, 0, 1'b1);
        lit(10, 78, 0, 1'b1);
        lit(10, 57, 0, 1'b0);
        lit(10, 79, 0, 1'b0);
        lit(9, 58, 0, 1'b1);
        lit(9, 59, 0, 1'b0);
        lit(11, 70, 0, 1'b0);

        // First-column rule: col 0 = 800 (row 148), previous line ends at 0
        ram0[0] = 12'd800;
        for (int i = 1; i < 15; i++) ram0[i] = 12'd400;
        ram0[15] = 12'd0;
        for (int y = 140; y <= 150; y++) line(y, 0, 16, 1'b1, -1, 2'b11);
        idle(4);
        lit(0, 148, 0, 1'b1);
        lit(0, 147, 0, 1'b0);
        lit(0, 140, 0, 1'b0);

        // Rows above the base never hit
        for (int i = 0; i < 16; i++) ram0[i] = 12'(i * 8);
        for (int y = 0; y <= 47; y++) line(y, 0, 16, 1'b0, -1, 2'b11);
        idle(4);
        lit(0, 47, 0, 1'b0);

        // Columns at or beyond 1024 never hit
        for (int i = 0; i < 1024; i++) ram0[i] = 12'd400;
        line(98, 1016, 16, 1'b0, -1, 2'b11);
        idle(4);
        lit(1020, 98, 0, 1'b1);
        lit(1023, 98, 0, 1'b1);
        lit(1025, 98, 0, 1'b0);
        lit(1031, 98, 0, 1'b0);

        // Reset mid-line at column 300
        ram0[0] = 12'd800;
        mode_line = 1'b1;
        for (int x = 290; x <= 300; x++) begin
            @(negedge clk);
            pixel_xpos = 11'(x);
            pixel_ypos = 11'd98;
            pixel_de = 1'b1;
        end
        #1 chk("pre-reset flag0", 32'(pixel_flag[0]), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid reset pixel_flag", 32'(pixel_flag), 32'd0);
        chk("mid reset pixel_de_o", 32'(pixel_de_o), 32'd0);
        chk("mid reset ram_rd_en", 32'(rif.ram_rd_en), 32'd0);
        @(negedge clk);
        pixel_de = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        for (int y = 140; y <= 150; y++) line(y, 0, 16, 1'b1, -1, 2'b11);
        idle(4);
        lit(0, 148, 0, 1'b1);
        lit(0, 145, 0, 1'b0);
        lit(0, 100, 0, 1'b0);

        idle(4);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/wave_trace_render.md
# wave_trace_render

Multi-channel waveform trace renderer for the signal-generator display path. It reads one stored sample per active pixel column from a shared multi-channel sample RAM and scales each sample to a screen row. It raises a per-channel hit flag when the current pixel lies on that channel's trace, either as single dots or as vertically connected line segments. It sits between the VGA/LCD timing generator (pixel_xpos/pixel_ypos/pixel_de) and the colour mixer.

## Interface
- ADDR_W, 10, sample RAM address width; columns at or beyond 2^ADDR_W never hit
- DATA_W, 12, sample width per channel
- PIX_W, 11, pixel coordinate width
- NUM_CH, 2, number of traces
- SHIFT, 3, right shift applied to a sample to get its row offset
- Y_BASE, 48, screen row of row offset 0
- RD_LAT, 1, RAM read latency in clocks (1 or 2)

- clk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- pixel_xpos  in  PIX_W  current column from the timing generator
- pixel_ypos  in  PIX_W  current row
- pixel_de  in  1  active-video qualifier
- mode_line  in  1  0 = dot mode, 1 = connected-line mode; sampled once per line at pixel_de rise
- ch_en  in  NUM_CH  per-channel enable; a disabled channel never flags
- ram_rd_en  out  1  RAM read enable
- ram_rd_addr  out  ADDR_W  RAM read address, shared by all channels
- ram_rd_data  in  NUM_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W]
- pixel_flag  out  NUM_CH  per-channel trace hit, aligned to pixel_de_o
- pixel_de_o  out  1  pixel_de delayed by the pipeline latency

## Operation
- Stage A (registered): ram_rd_addr <= pixel_xpos[ADDR_W-1:0]; ram_rd_en <= pixel_de; x_valid <= pixel_de && pixel_xpos < 2^ADDR_W.
- ypos, x_valid and de are carried through a delay line matching RAM latency.
- Stage B, per channel c: cur = ram_rd_data[c] >> SHIFT (width DATA_W-SHIFT). row = ypos_d - Y_BASE, computed with one extra sign bit. A negative row never hits.
- Dot mode: hit = (row == cur).
- Line mode: hit = min(prev,cur) <= row <= max(prev,cur), where prev is the previous column's cur on the same line.
- The first valid column of a line (de_d rising) loads prev = cur, so it behaves as a dot.
- prev updates only on cycles with de_d high. While de_d is low, prev holds.
- pixel_flag[c] <= hit && x_valid_d && ch_en[c]. ch_en is used undelayed; a change takes effect at the stage-B register.
- Latched mode changes mid-line are ignored until the next pixel_de rise.
- Reset: ram_rd_addr=0, ram_rd_en=0, pixel_flag=0, pixel_de_o=0, prev=0, all delay-line registers cleared. Reset mid-line drops all flags on the next edge. The first line after release starts with the first-column rule.

## Timing
- Latency from pixel inputs to pixel_flag/pixel_de_o is 2+RD_LAT clocks (3 at default).
- Throughput is one pixel per clock, with no stalls and no backpressure.
- ram_rd_en is high exactly on cycles following a pixel_de-high input. The RAM must present data RD_LAT clocks after the address edge.
- Comparator depth is one subtract and two compares per channel, all within one cycle.

## Structure
- Shared header/package wave_trace_pkg holds:
  - default widths, SHIFT and Y_BASE;
  - the row-offset width function (DATA_W-SHIFT);
  - the channel-slice macro.
- Sub-module wave_trace_cmp is instantiated NUM_CH times. It holds prev, the min/max logic and the flag register. The top keeps the address stage and the delay lines.

## Test plan
- Dot, constant sample: ch0 RAM all 400, SHIFT=3, Y_BASE=48 -> pixel_flag[0] high only on row 98, every column, 3 clocks after the input pixel.
- Line, step: ch0 sample col 9 = 80, col 10 = 240 (rows 58 and 78) -> column 10 flags on rows 58..78 inclusive; column 9 flags only on row 58.
- First column rule: line mode, col 0 = 800, previous line's last column = 0 -> col 0 flags only on row 148.
- Below base: any sample, ypos 0..47 -> no flag; col >= 1024 with PIX_W=11 -> no flag.
- Channels: ch1 ramp, ch_en=2'b01 -> pixel_flag[1] stays 0 while pixel_flag[0] behaves normally; set ch_en=2'b11 mid-frame -> ch1 flags from the next stage-B edge.
- Reset mid-line: assert rst_n low at column 300 -> all outputs 0 immediately; after release, the next line's first column uses the dot rule.
